// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder:
// func3 access encodings, MMIO register offsets and the error counter width.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } func3_e;

    // Byte offsets of the MMIO registers inside the 16-byte window
    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_GPIO   = 4'h4;
    localparam logic [3:0] OFF_ERRCNT = 4'h8;
    localparam logic [3:0] OFF_ERRCLR = 4'hC;

    localparam int ERRCNT_W = 16;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for byte/half/word accesses: byte enables and
// replicated store data on the write side, extraction and extension on the read side.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_raw,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_lanes,
    output logic [31:0] o_load,
    output logic        o_align_err,
    output logic        o_illegal_f3
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_be          = 4'b0000;
        o_wdata_lanes = i_wdata;
        o_load        = 32'h0;
        o_align_err   = 1'b0;
        o_illegal_f3  = 1'b0;
        case (i_func3)
            F3_B, F3_BU: begin
                o_be          = 4'b0001 << i_addr_lo;
                o_wdata_lanes = {4{i_wdata[7:0]}};
                o_load        = (i_func3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                                  : {24'h0, w_byte};
            end
            F3_H, F3_HU: begin
                o_align_err   = i_addr_lo[0];
                o_be          = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_lanes = {2{i_wdata[15:0]}};
                o_load        = (i_func3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                                  : {16'h0, w_half};
            end
            F3_W: begin
                o_align_err   = (i_addr_lo != 2'b00);
                o_be          = 4'b1111;
                o_wdata_lanes = i_wdata;
                o_load        = i_raw;
            end
            default: begin
                o_illegal_f3 = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory responder: little-endian byte-addressable RAM plus an MMIO window
// holding a cycle counter, a GPIO output register and the error flag/counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                    DM_ADDRESS = 9,
    parameter int                    DATA_W     = 32,
    parameter logic [DM_ADDRESS-1:0] MMIO_BASE  = 9'h1F0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  reade,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DATA_W-1:0]     gpio_out,
    output logic                  misalign_err,
    output logic [ERRCNT_W-1:0]   err_count
);

    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    logic [DATA_W-1:0]   r_mem [WORDS];
    logic [DATA_W-1:0]   r_cycle;
    logic [DATA_W-1:0]   r_gpio;
    logic                r_err_flag;
    logic [ERRCNT_W-1:0] r_err_count;

    logic [DM_ADDRESS-3:0] w_word_idx;
    logic                  w_is_mmio;
    logic [3:0]            w_off;
    logic [DATA_W-1:0]     w_mmio_word;
    logic [DATA_W-1:0]     w_raw;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_lanes;
    logic [DATA_W-1:0]     w_load;
    logic                  w_align_err;
    logic                  w_illegal_f3;
    logic                  w_req;
    logic                  w_err;
    logic                  w_store_ok;
    logic                  w_clr_req;

    assign w_word_idx = addr[DM_ADDRESS-1:2];
    assign w_is_mmio  = (addr[DM_ADDRESS-1:4] == MMIO_BASE[DM_ADDRESS-1:4]);
    assign w_off      = {addr[3:2], 2'b00};

    always_comb begin
        w_mmio_word = '0;
        case (w_off)
            OFF_CYCLE:  w_mmio_word = r_cycle;
            OFF_GPIO:   w_mmio_word = r_gpio;
            OFF_ERRCNT: w_mmio_word = {{(DATA_W-ERRCNT_W){1'b0}}, r_err_count};
            OFF_ERRCLR: w_mmio_word = {{(DATA_W-1){1'b0}}, r_err_flag};
            default:    w_mmio_word = '0;
        endcase
    end

    assign w_raw = w_is_mmio ? w_mmio_word : r_mem[w_word_idx];

    dmem_lane_align u_lane_align (
        .i_func3       (func3),
        .i_addr_lo     (addr[1:0]),
        .i_raw         (w_raw),
        .i_wdata       (wr_data),
        .o_be          (w_be),
        .o_wdata_lanes (w_lanes),
        .o_load        (w_load),
        .o_align_err   (w_align_err),
        .o_illegal_f3  (w_illegal_f3)
    );

    // Unsigned-load encodings have no store counterpart, so SBU/SHU count as illegal.
    assign w_req      = wr | reade;
    assign w_err      = w_req & (w_align_err | w_illegal_f3 | (wr & reade) |
                                 (wr & ((func3 == F3_BU) | (func3 == F3_HU))));
    assign w_store_ok = wr & ~reade & ~w_err & ~reset;
    assign w_clr_req  = wr & w_is_mmio & (w_off == OFF_ERRCLR);

    assign rd_data = (reade & ~w_err & ~reset) ? w_load : '0;

    // NOTE: the RAM array has no reset; contents survive reset and need no clearing logic.
    always_ff @(posedge clk) begin
        if (w_store_ok && !w_is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_lanes[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
            r_gpio  <= '0;
        end else begin
            r_cycle <= r_cycle + DATA_W'(1);
            if (w_store_ok && w_is_mmio && (w_off == OFF_GPIO)) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) r_gpio[8*i +: 8] <= w_lanes[8*i +: 8];
                end
            end
        end
    end

    // A new error outranks a simultaneous clear, including an erroring write to ERRCLR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end else if (w_err) begin
            r_err_flag <= 1'b1;
            if (w_clr_req)
                r_err_count <= ERRCNT_W'(1);
            else if (r_err_count != {ERRCNT_W{1'b1}})
                r_err_count <= r_err_count + ERRCNT_W'(1);
        end else if (w_clr_req) begin
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end
    end

    assign gpio_out     = r_gpio;
    assign misalign_err = r_err_flag;
    assign err_count    = r_err_count;

endmodule
